// File: rtl/garage_pkg.sv
// Shared definitions for the garage door plant model and its controller:
// state encoding, default travel geometry and a small state decode helper.
package garage_pkg;

    localparam int TRAVEL_MAX_DEF = 16;
    localparam int STEP_DIV_DEF   = 4;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_STOPPED = 3'd4,
        ST_FAULT   = 3'd5
    } door_state_e;

    // True while the motor is actually driving the door.
    function automatic logic state_is_moving(input door_state_e st);
        logic mv;
        case (st)
            ST_OPENING: mv = 1'b1;
            ST_CLOSING: mv = 1'b1;
            default:    mv = 1'b0;
        endcase
        return mv;
    endfunction

endpackage

// File: rtl/door_step_div.sv
// Step prescaler: emits one tick every STEP_DIV cycles of 'run'.
// 'clear' discards any partial count so the current cycle counts as the
// first cycle of a fresh step; dropping 'run' also discards the count.
module door_step_div #(
    parameter int STEP_DIV = garage_pkg::STEP_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_eff_s;

    // Next count and same-cycle tick when the step boundary is reached.
    always_comb begin
        cnt_d = {CNT_W{1'b0}};
        tick  = 1'b0;
        if (clear) begin
            cnt_eff_s = {CNT_W{1'b0}};
        end else begin
            cnt_eff_s = cnt_q;
        end
        if (run) begin
            if (cnt_eff_s == CNT_LAST) begin
                tick  = 1'b1;
                cnt_d = {CNT_W{1'b0}};
            end else begin
                tick  = 1'b0;
                cnt_d = cnt_eff_s + CNT_W'(1);
            end
        end else begin
            tick  = 1'b0;
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/garage_door_model.sv
// Behavioural plant model of a garage door: integrates motor commands into
// a position, reports limit switches, and latches a fault if the motor is
// ever driven both ways at once.
module garage_door_model
    import garage_pkg::*;
#(
    parameter int TRAVEL_MAX = TRAVEL_MAX_DEF,
    parameter int STEP_DIV   = STEP_DIV_DEF,
    parameter int POS_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             UP_M,
    input  logic             DN_M,
    output logic             UP_MAX,
    output logic             DN_MAX,
    output logic [POS_W-1:0] pos,
    output logic             moving,
    output logic             fault,
    output logic             overdrive
);

    localparam logic [POS_W-1:0] POS_TOP = POS_W'(TRAVEL_MAX);
    localparam logic [POS_W-1:0] POS_BOT = {POS_W{1'b0}};
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    door_state_e      state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             fault_q, fault_d;
    logic             od_q, od_d;
    logic             armed_q, armed_d;   // overdrive may fire again
    logic [1:0]       dir_q, dir_d;       // travel direction of the previous cycle

    logic live_s, up_only_s, dn_only_s, at_top_s, at_bot_s, push_s;
    logic run_s, clear_s, tick_s;

    door_step_div #(.STEP_DIV(STEP_DIV)) u_step_div (
        .clk   (clk),
        .rst   (rst),
        .run   (run_s),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Decode commands against the limits into a travel direction.
    always_comb begin
        live_s    = state_q inside {ST_CLOSED, ST_OPENING, ST_OPEN, ST_CLOSING, ST_STOPPED};
        up_only_s = UP_M & ~DN_M;
        dn_only_s = DN_M & ~UP_M;
        at_top_s  = (pos_q == POS_TOP);
        at_bot_s  = (pos_q == POS_BOT);
        push_s    = live_s & ((up_only_s & at_top_s) | (dn_only_s & at_bot_s));
        dir_d     = DIR_NONE;
        if (live_s && up_only_s && !at_top_s) begin
            dir_d = DIR_UP;
        end else if (live_s && dn_only_s && !at_bot_s) begin
            dir_d = DIR_DN;
        end else begin
            dir_d = DIR_NONE;
        end
        run_s   = (dir_d != DIR_NONE);
        clear_s = run_s && (dir_d != dir_q);
    end

    // Next state, position and flags.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        fault_d = fault_q;
        od_d    = 1'b0;
        armed_d = armed_q;
        case (state_q)
            ST_CLOSED, ST_OPENING, ST_OPEN, ST_CLOSING, ST_STOPPED: begin
                if (UP_M && DN_M) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    if (dir_d == DIR_UP) begin
                        if (tick_s) begin
                            pos_d = pos_q + POS_W'(1);
                        end else begin
                            pos_d = pos_q;
                        end
                        state_d = (pos_d == POS_TOP) ? ST_OPEN : ST_OPENING;
                    end else if (dir_d == DIR_DN) begin
                        if (tick_s) begin
                            pos_d = pos_q - POS_W'(1);
                        end else begin
                            pos_d = pos_q;
                        end
                        state_d = (pos_d == POS_BOT) ? ST_CLOSED : ST_CLOSING;
                    end else begin
                        pos_d = pos_q;
                        if (at_top_s) begin
                            state_d = ST_OPEN;
                        end else if (at_bot_s) begin
                            state_d = ST_CLOSED;
                        end else begin
                            state_d = ST_STOPPED;
                        end
                    end
                    od_d    = push_s & armed_q;
                    armed_d = ~push_s;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
            default: begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLOSED;
            pos_q   <= POS_BOT;
            fault_q <= 1'b0;
            od_q    <= 1'b0;
            armed_q <= 1'b1;
            dir_q   <= DIR_NONE;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            fault_q <= fault_d;
            od_q    <= od_d;
            armed_q <= armed_d;
            dir_q   <= dir_d;
        end
    end

    assign pos       = pos_q;
    assign UP_MAX    = (pos_q == POS_TOP);
    assign DN_MAX    = (pos_q == POS_BOT);
    assign moving    = state_is_moving(state_q);
    assign fault     = fault_q;
    assign overdrive = od_q;

endmodule

// File: tb/tb_garage_door_model.sv
// Self-checking bench for garage_door_model with an 8-position door and
// two clocks per step: fixed vector table, directed travel sequences and
// randomized commands compared against a cycle-count reference model.
module tb_garage_door_model;

    localparam int TMAX = 8;
    localparam int SDIV = 2;
    localparam int PW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          up_m = 1'b0;
    logic          dn_m = 1'b0;
    logic          up_max, dn_max, moving, fault, overdrive;
    logic [PW-1:0] pos;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position, consecutive travel cycles, flags.
    int m_pos;
    int m_run;
    int m_dir_prev;
    bit m_fault, m_od, m_armed, m_moving;

    garage_door_model #(.TRAVEL_MAX(TMAX), .STEP_DIV(SDIV), .POS_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .UP_M      (up_m),
        .DN_M      (dn_m),
        .UP_MAX    (up_max),
        .DN_MAX    (dn_max),
        .pos       (pos),
        .moving    (moving),
        .fault     (fault),
        .overdrive (overdrive)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         r, u, d;
        logic [7:0] pos;
        bit         upmax, dnmax, mov, flt, od;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The door advances one position for every SDIV consecutive cycles of
    // unobstructed travel in one direction.
    task automatic model_step(input bit r, input bit u, input bit d);
        int dir;
        bit lim;
        if (r) begin
            m_pos = 0; m_run = 0; m_dir_prev = 0;
            m_fault = 0; m_od = 0; m_armed = 1; m_moving = 0;
        end else if (m_fault) begin
            m_od = 0; m_moving = 0;
        end else if (u && d) begin
            m_fault = 1; m_od = 0; m_moving = 0; m_run = 0; m_dir_prev = 0;
        end else begin
            dir = u ? 1 : (d ? -1 : 0);
            lim = (dir == 1 && m_pos == TMAX) || (dir == -1 && m_pos == 0);
            m_od    = lim && m_armed;
            m_armed = !lim;
            if (dir != 0 && !lim) begin
                m_run = (dir == m_dir_prev) ? m_run + 1 : 1;
                if (m_run % SDIV == 0) m_pos += dir;
                m_moving   = (dir == 1) ? (m_pos != TMAX) : (m_pos != 0);
                m_dir_prev = dir;
            end else begin
                m_run = 0; m_moving = 0; m_dir_prev = 0;
            end
        end
    endtask

    function automatic logic [12:0] model_vec();
        logic [7:0] p;
        p = 8'(m_pos);
        return {p, m_pos == TMAX, m_pos == 0, m_moving, m_fault, m_od};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {pos, up_max, dn_max, moving, fault, overdrive};
    endfunction

    task automatic cycle(input bit r, input bit u, input bit d);
        rst = r; up_m = u; dn_m = d;
        @(posedge clk);
        #1;
        model_step(r, u, d);
    endtask

    initial begin
        int od_cnt;
        int cmd;
        int sel;
        bit r;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Vector table: reset, stepping, reversal, limits, overdrive, fault.
        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].r, tbl[i].u, tbl[i].d);
            check($sformatf("vec%0d", i), 32'(dut_vec()),
                  32'({tbl[i].pos, tbl[i].upmax, tbl[i].dnmax, tbl[i].mov, tbl[i].flt, tbl[i].od}));
        end

        // Full opening: one step every two cycles, OPEN at cycle 16.
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            check($sformatf("open_pos_c%0d", k), 32'(pos), 32'(k / 2));
        end
        check("open_upmax", 32'(up_max), 32'd1);
        check("open_not_moving", 32'(moving), 32'd0);

        // Pushing into the upper limit: single overdrive pulse.
        od_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            od_cnt += int'(overdrive);
        end
        check("od_count", 32'(od_cnt), 32'd1);
        check("od_pos_held", 32'(pos), 32'd8);

        // Full closing takes exactly 16 cycles.
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 1'b0, 1'b1);
            if (k == 15) check("close_pos_c15", 32'(pos), 32'd1);
        end
        check("close_pos", 32'(pos), 32'd0);
        check("close_dnmax", 32'(dn_max), 32'd1);
        check("close_not_moving", 32'(moving), 32'd0);

        // Interrupted command discards the partial step.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("restart_drop", 32'(pos), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check("restart_c1", 32'(pos), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        check("restart_c2", 32'(pos), 32'd1);

        // Conflicting commands at pos 3 latch a fault until reset.
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b0);
        check("fault_pre_pos", 32'(pos), 32'd3);
        cycle(1'b0, 1'b1, 1'b1);
        check("fault_set", 32'({fault, moving}), 32'b10);
        check("fault_pos", 32'(pos), 32'd3);
        for (int k = 0; k < 3; k++) cycle(1'b0, k[0], ~k[0]);
        check("fault_sticky", 32'({pos, fault}), 32'({8'd3, 1'b1}));
        cycle(1'b1, 1'b1, 1'b1);
        check("fault_rst", 32'({pos, fault, dn_max}), 32'({8'd0, 1'b0, 1'b1}));

        // Reset mid-closing overrides the held command.
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b1);
        check("closing_pos5", 32'({pos, moving}), 32'({8'd5, 1'b1}));
        cycle(1'b1, 1'b0, 1'b1);
        check("rst_mid_travel", 32'({pos, dn_max, moving}), 32'({8'd0, 1'b1, 1'b0}));

        // Randomized commands against the reference model.
        cmd = 0;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0) || (m_fault && ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 99) < 12) begin
                sel = int'($urandom_range(0, 99));
                cmd = (sel < 30) ? 0 : (sel < 62) ? 1 : (sel < 96) ? 2 : 3;
            end
            cycle(r, (cmd == 1) || (cmd == 3), (cmd == 2) || (cmd == 3));
            check($sformatf("rand%0d", i), 32'(dut_vec()), 32'(model_vec()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/garage_door_model.md
GARAGE_DOOR_MODEL -- requirements
Module: garage_door_model

Interface
REQ-001 SHALL have parameter TRAVEL_MAX, default 16, meaning full-open position count (>=2).
REQ-002 SHALL have parameter STEP_DIV, default 4, meaning clocks per one position step (>=1).
REQ-003 SHALL have parameter POS_W, default 8, meaning width of the position register (2^POS_W > TRAVEL_MAX).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port UP_M, input, 1, motor-up command from the controller.
REQ-007 SHALL have port DN_M, input, 1, motor-down command from the controller.
REQ-008 SHALL have port UP_MAX, output, 1, upper limit switch; high while pos == TRAVEL_MAX.
REQ-009 SHALL have port DN_MAX, output, 1, lower limit switch; high while pos == 0.
REQ-010 SHALL have port pos, output, POS_W, current door position (0 = closed).
REQ-011 SHALL have port moving, output, 1, high in OPENING or CLOSING.
REQ-012 SHALL have port fault, output, 1, sticky fault flag.
REQ-013 SHALL have port overdrive, output, 1, one-cycle pulse when the motor is commanded into an active limit.

Function
REQ-014 SHALL implement states CLOSED, OPENING, OPEN, CLOSING, STOPPED, FAULT.
REQ-015 SHALL enter FAULT from any state on the first cycle UP_M and DN_M are both high; FAULT exits only on rst.
REQ-016 In FAULT: pos frozen, moving=0, fault=1, divider held at 0.
REQ-017 UP_M=1, DN_M=0, pos < TRAVEL_MAX: state OPENING; divider counts 0..STEP_DIV-1; on the cycle it equals STEP_DIV-1, pos increments by 1 and the divider clears.
REQ-018 DN_M=1, UP_M=0, pos > 0: state CLOSING; symmetric, pos decrements by 1 every STEP_DIV clocks.
REQ-019 First pos change SHALL occur exactly STEP_DIV cycles after the first cycle the command is sampled high.
REQ-020 The divider SHALL clear whenever the command drops or reverses direction; partial counts are discarded.
REQ-021 pos SHALL saturate: never above TRAVEL_MAX, never below 0.
REQ-022 When pos reaches TRAVEL_MAX, state SHALL become OPEN; when pos reaches 0, state SHALL become CLOSED.
REQ-023 In OPEN with UP_M=1 (or CLOSED with DN_M=1), overdrive SHALL pulse once on the first such cycle and re-arm only after the command drops.
REQ-024 No command with 0 < pos < TRAVEL_MAX: state STOPPED, pos held.
REQ-025 UP_MAX/DN_MAX SHALL be combinational decodes of registered pos; zero cycles after pos updates.
REQ-026 moving SHALL be decoded from state only.

Reset
REQ-027 On rst=1 at a clock edge: state CLOSED, pos=0, divider=0, fault=0, overdrive=0, moving=0; hence DN_MAX=1, UP_MAX=0.
REQ-028 rst asserted mid-travel or in FAULT SHALL override all other inputs in that cycle.

Structure
REQ-029 State encoding and default TRAVEL_MAX/STEP_DIV SHALL reside in a shared package garage_pkg, also usable by the controller.
REQ-030 The step prescaler SHALL be a sub-module door_step_div (inputs clk, rst, run, clear; output tick).

Verification (TRAVEL_MAX=8, STEP_DIV=2)
REQ-031 Reset, then UP_M=1 held -> pos steps 1..8 on cycles 2,4,...,16; UP_MAX=1 at cycle 16; state OPEN.
REQ-032 In OPEN, hold UP_M=1 for 5 cycles -> pos stays 8; overdrive high exactly 1 cycle.
REQ-033 From pos=8, DN_M=1 held -> pos reaches 0 after 16 cycles; DN_MAX=1; state CLOSED.
REQ-034 UP_M=1 for 1 cycle, drop, reassert -> no pos change until 2 cycles after reassertion.
REQ-035 At pos=3 moving up, assert DN_M alongside UP_M -> fault=1 next cycle; pos stays 3 until rst; rst -> pos=0, fault=0.
REQ-036 Assert rst during CLOSING at pos=5 -> next cycle pos=0, DN_MAX=1, moving=0.
